// File: rtl/ntt_stage_scheduler.sv
// Stage sequencer for an in-place radix-2 NTT: issues one butterfly per cycle,
// replays the address pair as write-back BF_LATENCY cycles later, drains between stages.
module ntt_stage_scheduler #(
  parameter int LOG_N      = 2,
  parameter int BF_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [LOG_N-1:0] stage,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-2:0] tw_idx,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int               DW     = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam logic [LOG_N-2:0] K_LAST = '1;
  localparam logic [LOG_N-1:0] S_LAST = LOG_N'(LOG_N - 1);
  localparam logic [DW-1:0]    D_LAST = DW'(BF_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LOG_N-1:0] s_q, s_d;
  logic [LOG_N-2:0] k_q, k_d;
  logic [DW-1:0]    d_q, d_d;

  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [LOG_N-1:0] stage_q, stage_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
  logic [LOG_N-2:0] tw_idx_q, tw_idx_d;

  logic             pipe_en_q [BF_LATENCY];
  logic             pipe_en_d [BF_LATENCY];
  logic [LOG_N-1:0] pipe_a_q  [BF_LATENCY];
  logic [LOG_N-1:0] pipe_a_d  [BF_LATENCY];
  logic [LOG_N-1:0] pipe_b_q  [BF_LATENCY];
  logic [LOG_N-1:0] pipe_b_d  [BF_LATENCY];

  logic [LOG_N-1:0] k_ext, half, addr_a;
  logic [LOG_N-2:0] j_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      k_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    d_d     = d_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          s_d     = '0;
          k_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
          d_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        if (d_q == D_LAST) begin
          d_d = '0;
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            s_d     = s_q + 1'b1;
            state_d = ISSUE;
          end
        end else begin
          d_d = d_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the next state so they land registered in the same cycle as the state.
  always_comb begin
    k_ext  = {1'b0, k_d};
    half   = {{(LOG_N-1){1'b0}}, 1'b1} << s_d;
    j_lo   = k_d & ~({(LOG_N-1){1'b1}} << s_d);
    addr_a = ((k_ext >> s_d) << (s_d + 1'b1)) | {1'b0, j_lo};

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    stage_d = s_d;
    rd_en_d = (state_d == ISSUE);
    if (state_d == ISSUE) begin
      rd_addr_a_d = addr_a;
      rd_addr_b_d = addr_a + half;
      tw_idx_d    = j_lo << (S_LAST - s_d);
    end else begin
      rd_addr_a_d = rd_addr_a_q;
      rd_addr_b_d = rd_addr_b_q;
      tw_idx_d    = tw_idx_q;
    end

    pipe_en_d[0] = rd_en_q;
    pipe_a_d[0]  = rd_addr_a_q;
    pipe_b_d[0]  = rd_addr_b_q;
    for (int i = 1; i < BF_LATENCY; i++) begin
      pipe_en_d[i] = pipe_en_q[i-1];
      pipe_a_d[i]  = pipe_a_q[i-1];
      pipe_b_d[i]  = pipe_b_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_q     <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_idx_q    <= '0;
      for (int i = 0; i < BF_LATENCY; i++) begin
        pipe_en_q[i] <= 1'b0;
        pipe_a_q[i]  <= '0;
        pipe_b_q[i]  <= '0;
      end
    end else begin
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stage_q     <= stage_d;
      rd_en_q     <= rd_en_d;
      rd_addr_a_q <= rd_addr_a_d;
      rd_addr_b_q <= rd_addr_b_d;
      tw_idx_q    <= tw_idx_d;
      for (int i = 0; i < BF_LATENCY; i++) begin
        pipe_en_q[i] <= pipe_en_d[i];
        pipe_a_q[i]  <= pipe_a_d[i];
        pipe_b_q[i]  <= pipe_b_d[i];
      end
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = stage_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_addr_a_q;
  assign rd_addr_b = rd_addr_b_q;
  assign tw_idx    = tw_idx_q;
  assign wr_en     = pipe_en_q[BF_LATENCY-1];
  assign wr_addr_a = pipe_a_q[BF_LATENCY-1];
  assign wr_addr_b = pipe_b_q[BF_LATENCY-1];

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Bench for ntt_stage_scheduler: three parameterisations driven by one start/reset,
// each compared every cycle against a transaction-level schedule model.
module tb_ntt_stage_scheduler;

  localparam int NI = 3;
  localparam int OW = 65;
  localparam int LN  [NI] = '{2, 3, 4};
  localparam int LAT [NI] = '{2, 1, 8};

  // Expected default-parameter trace: rd_en, ra, rb, tw, wr_en, wa, wb, done, ready
  localparam int TBL [10][9] = '{
    '{1, 0, 1, 0, 0, 0, 0, 0, 0},
    '{1, 2, 3, 0, 0, 0, 0, 0, 0},
    '{0, 2, 3, 0, 1, 0, 1, 0, 0},
    '{0, 2, 3, 0, 1, 2, 3, 0, 0},
    '{1, 0, 2, 0, 0, 0, 0, 0, 0},
    '{1, 1, 3, 1, 0, 0, 0, 0, 0},
    '{0, 1, 3, 1, 1, 0, 2, 0, 0},
    '{0, 1, 3, 1, 1, 1, 3, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 1, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0, 1}
  };

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [OW-1:0] obs [NI];

  int  vectors = 0;
  int  miscompares = 0;
  int  t_m [NI];
  bit  fresh [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = LN[g];
    localparam int B = LAT[g];
    logic         ready, busy, done, rd_en, wr_en;
    logic [L-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [L-2:0] tw_idx;
    ntt_stage_scheduler #(.LOG_N(L), .BF_LATENCY(B)) dut (
      .clk(clk), .reset(reset), .start(start),
      .ready(ready), .busy(busy), .done(done), .stage(stage),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );
    assign obs[g] = {ready, busy, done, 10'(stage), rd_en, 10'(rd_addr_a), 10'(rd_addr_b),
                     10'(tw_idx), wr_en, 10'(wr_addr_a), 10'(wr_addr_b)};
  end

  function automatic int total(input int i);
    return LN[i] * ((1 << (LN[i] - 1)) + LAT[i]) + 1;
  endfunction

  task automatic bf_addr(input int ln, input int s, input int k, output int a, output int b, output int tw);
    int half;
    half = 1 << s;
    a    = (k / half) * 2 * half + (k % half);
    b    = a + half;
    tw   = (k % half) * (1 << (ln - 1 - s));
  endtask

  // Expected outputs of instance i at its current position t_m[i] within a transform.
  task automatic model(input int i, output logic [OW-1:0] ev, output logic [OW-1:0] mk);
    int ln, lat, n2, p, t, s, r, k, stg, a, b, tw, wa, wb, twx;
    logic rdy, bsy, dn, rd, wr;
    ln = LN[i]; lat = LAT[i]; n2 = 1 << (ln - 1); p = n2 + lat; t = t_m[i];
    rdy = 1'b0; bsy = 1'b0; dn = 1'b0; rd = 1'b0; wr = 1'b0;
    stg = 0; a = 0; b = 0; tw = 0; wa = 0; wb = 0;
    mk = '1;
    if (t == 0) begin
      rdy = 1'b1;
      if (!fresh[i]) begin
        mk[50:21] = '0;
        mk[19:0]  = '0;
      end
    end else if (t == total(i)) begin
      bsy = 1'b1; dn = 1'b1; stg = ln - 1;
      mk[50:21] = '0;
      mk[19:0]  = '0;
    end else begin
      bsy = 1'b1;
      s   = (t - 1) / p;
      r   = (t - 1) % p;
      stg = s;
      rd  = (r < n2);
      k   = rd ? r : n2 - 1;
      bf_addr(ln, s, k, a, b, tw);
      wr  = (r >= lat) && (r - lat < n2);
      if (wr) bf_addr(ln, s, r - lat, wa, wb, twx);
      else mk[19:0] = '0;
    end
    ev = {rdy, bsy, dn, 10'(stg), rd, 10'(a), 10'(b), 10'(tw), wr, 10'(wa), 10'(wb)};
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        t_m[i] = 0; fresh[i] = 1'b1;
      end else if (t_m[i] == 0) begin
        if (start) begin t_m[i] = 1; fresh[i] = 1'b0; end
      end else if (t_m[i] == total(i)) begin
        t_m[i] = 0;
      end else begin
        t_m[i] = t_m[i] + 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [OW-1:0] ev, mk;
    #1 reset = 1'b1; start = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      model(i, ev, mk); vectors++;
      if ((obs[i] & mk) !== (ev & mk)) begin
        miscompares++;
        $display("FAIL reset_noclk inst%0d: got %h expected %h", i, obs[i] & mk, ev & mk);
      end
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        model(i, ev, mk); vectors++;
        if ((obs[i] & mk) !== (ev & mk)) begin
          miscompares++;
          $display("FAIL reset_clk inst%0d c=%0d: got %h expected %h", i, c, obs[i] & mk, ev & mk);
        end
      end
    end
    reset = 1'b0; start = 1'b0;
    tick();
    for (int i = 0; i < NI; i++) begin
      model(i, ev, mk); vectors++;
      if ((obs[i] & mk) !== (ev & mk)) begin
        miscompares++;
        $display("FAIL reset_release inst%0d: got %h expected %h", i, obs[i] & mk, ev & mk);
      end
    end
  endtask

  task automatic test_default_trace();
    logic [OW-1:0] ev, mk;
    int got [9];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      got = '{int'(gi[0].rd_en), int'(gi[0].rd_addr_a), int'(gi[0].rd_addr_b), int'(gi[0].tw_idx),
              int'(gi[0].wr_en), int'(gi[0].wr_addr_a), int'(gi[0].wr_addr_b),
              int'(gi[0].done), int'(gi[0].ready)};
      for (int f = 0; f < 9; f++) begin
        if (!((f >= 1 && f <= 3 && c > 8) || (f >= 5 && f <= 6 && TBL[c-1][4] == 0))) begin
          vectors++;
          if (got[f] !== TBL[c-1][f]) begin
            miscompares++;
            $display("FAIL default_trace cycle %0d field %0d: got %0d expected %0d", c, f, got[f], TBL[c-1][f]);
          end
        end
      end
      for (int i = 0; i < NI; i++) begin
        model(i, ev, mk); vectors++;
        if ((obs[i] & mk) !== (ev & mk)) begin
          miscompares++;
          $display("FAIL trace_model inst%0d t=%0d: got %h expected %h", i, t_m[i], obs[i] & mk, ev & mk);
        end
      end
      tick();
    end
  endtask

  task automatic test_random_pulses();
    logic [OW-1:0] ev, mk;
    for (int c = 0; c < 200; c++) begin
      start = ($urandom_range(0, 7) == 0);
      tick();
      for (int i = 0; i < NI; i++) begin
        model(i, ev, mk); vectors++;
        if ((obs[i] & mk) !== (ev & mk)) begin
          miscompares++;
          $display("FAIL random inst%0d t=%0d: got %h expected %h", i, t_m[i], obs[i] & mk, ev & mk);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] ev, mk;
    int done_at = -100;
    int dones = 0;
    start = 1'b1;
    for (int c = 0; c < 150; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        model(i, ev, mk); vectors++;
        if ((obs[i] & mk) !== (ev & mk)) begin
          miscompares++;
          $display("FAIL b2b inst%0d t=%0d: got %h expected %h", i, t_m[i], obs[i] & mk, ev & mk);
        end
      end
      if (c == done_at + 1) begin
        vectors++;
        if (gi[0].ready !== 1'b1 || gi[0].rd_en !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_idle_gap: got ready=%b rd_en=%b expected ready=1 rd_en=0", gi[0].ready, gi[0].rd_en);
        end
      end
      if (c == done_at + 2) begin
        vectors++;
        if (gi[0].rd_en !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_restart: got rd_en=%b expected 1 two cycles after done", gi[0].rd_en);
        end
      end
      if (gi[0].done === 1'b1) begin
        done_at = c;
        dones++;
      end
    end
    vectors++;
    if (dones < 10) begin
      miscompares++;
      $display("FAIL b2b_done_count: got %0d expected at least 10", dones);
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [OW-1:0] ev, mk;
    for (int c = 0; c < 80; c++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    for (int i = 0; i < NI; i++) begin
      model(i, ev, mk); vectors++;
      if ((obs[i] & mk) !== (ev & mk)) begin
        miscompares++;
        $display("FAIL pre_reset inst%0d t=%0d: got %h expected %h", i, t_m[i], obs[i] & mk, ev & mk);
      end
    end
    #2 reset = 1'b1;
    for (int i = 0; i < NI; i++) begin t_m[i] = 0; fresh[i] = 1'b1; end
    #1;
    for (int i = 0; i < NI; i++) begin
      model(i, ev, mk); vectors++;
      if ((obs[i] & mk) !== (ev & mk)) begin
        miscompares++;
        $display("FAIL reset_async inst%0d: got %h expected %h", i, obs[i] & mk, ev & mk);
      end
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        model(i, ev, mk); vectors++;
        if ((obs[i] & mk) !== (ev & mk)) begin
          miscompares++;
          $display("FAIL post_reset inst%0d c=%0d: got %h expected %h", i, c, obs[i] & mk, ev & mk);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin t_m[i] = 0; fresh[i] = 1'b1; end
    test_reset();
    test_default_trace();
    test_random_pulses();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
